// File: rtl/mem_arbiter.sv
// Round-robin arbiter funnelling several requesters into one pipelined memory port.
// In-order responses are routed back to their issuers through an ID FIFO of issuer indices.
module mem_arbiter #(
  parameter int num_req_p     = 2,
  parameter int width_words_p = 4,
  parameter int max_outst_p   = 4
) (
  input  logic                                        clk_i,
  input  logic                                        reset_i,
  input  logic [num_req_p-1:0]                        req_valid_i,
  output logic [num_req_p-1:0]                        req_ready_o,
  input  logic [num_req_p-1:0]                        req_we_i,
  input  logic [num_req_p-1:0][31:0]                  req_addr_i,
  input  logic [num_req_p-1:0][32*width_words_p-1:0]  req_wdata_i,
  output logic [num_req_p-1:0]                        resp_valid_o,
  output logic [32*width_words_p-1:0]                 resp_data_o,
  output logic                                        mem_valid_o,
  input  logic                                        mem_ready_i,
  output logic                                        mem_we_o,
  output logic [31:0]                                 mem_addr_o,
  output logic [32*width_words_p-1:0]                 mem_wdata_o,
  input  logic                                        mem_valid_i,
  input  logic [32*width_words_p-1:0]                 mem_data_i,
  output logic [$clog2(max_outst_p):0]                outst_o,
  output logic                                        err_o
);

  localparam int IW = $clog2(num_req_p);
  localparam int PW = $clog2(max_outst_p);
  localparam int OW = PW + 1;
  localparam logic [OW-1:0] MAX_OUTST = OW'(max_outst_p);
  localparam logic [IW-1:0] LAST_IDX  = IW'(num_req_p - 1);

  logic [IW-1:0] rr_r;
  logic          lock_r;
  logic [IW-1:0] lock_idx_r;
  logic [OW-1:0] outst_r;
  logic [IW-1:0] fifo_r [max_outst_p];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic          err_r;

  logic [IW-1:0] cand_idx_s;
  logic          found_s;
  logic [IW-1:0] grant_idx_s;
  logic          credit_s;
  logic          accept_s;
  logic          fifo_empty_s;
  logic          pop_s;
  logic          stray_s;

  // Round-robin candidate: first valid requester at or after rr_r, wrapping.
  always_comb begin
    int j;
    logic [IW-1:0] idx;
    j          = 0;
    idx        = '0;
    cand_idx_s = rr_r;
    found_s    = 1'b0;
    for (int i = 0; i < num_req_p; i++) begin
      j = int'(rr_r) + i;
      if (j >= num_req_p) begin
        j = j - num_req_p;
      end else begin
        j = j;
      end
      idx = IW'(j);
      if (!found_s && req_valid_i[idx]) begin
        found_s    = 1'b1;
        cand_idx_s = idx;
      end else begin
        found_s    = found_s;
      end
    end
  end

  // Grant and handshake; a stalled grant is held until the memory takes it.
  always_comb begin
    if (lock_r && req_valid_i[lock_idx_r]) begin
      grant_idx_s = lock_idx_r;
    end else begin
      grant_idx_s = cand_idx_s;
    end
    credit_s     = (outst_r < MAX_OUTST);
    mem_valid_o  = ~reset_i & (|req_valid_i) & credit_s;
    mem_we_o     = req_we_i[grant_idx_s];
    mem_addr_o   = req_addr_i[grant_idx_s];
    mem_wdata_o  = req_wdata_i[grant_idx_s];
    accept_s     = mem_valid_o & mem_ready_i;
    if (accept_s) begin
      req_ready_o = num_req_p'(1'b1) << grant_idx_s;
    end else begin
      req_ready_o = '0;
    end
  end

  // Response routing straight from the memory strobe to the FIFO head's owner.
  always_comb begin
    fifo_empty_s = (outst_r == {OW{1'b0}});
    pop_s        = ~reset_i & mem_valid_i & ~fifo_empty_s;
    stray_s      = ~reset_i & mem_valid_i & fifo_empty_s;
    resp_data_o  = mem_data_i;
    if (pop_s) begin
      resp_valid_o = num_req_p'(1'b1) << fifo_r[rd_ptr_r];
    end else begin
      resp_valid_o = '0;
    end
  end

  // State: round-robin pointer, grant lock, ID FIFO, credit counter, sticky error.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      rr_r       <= '0;
      lock_r     <= 1'b0;
      lock_idx_r <= '0;
      outst_r    <= '0;
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      err_r      <= 1'b0;
      for (int i = 0; i < max_outst_p; i++) begin
        fifo_r[i] <= '0;
      end
    end else begin
      if (accept_s) begin
        fifo_r[wr_ptr_r] <= grant_idx_s;
        wr_ptr_r         <= wr_ptr_r + PW'(1'b1);
        rr_r             <= (grant_idx_s == LAST_IDX) ? {IW{1'b0}} : grant_idx_s + IW'(1'b1);
        lock_r           <= 1'b0;
      end else if (mem_valid_o) begin
        lock_r     <= 1'b1;
        lock_idx_r <= grant_idx_s;
      end else begin
        lock_r     <= lock_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1'b1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({accept_s, pop_s})
        2'b10:   outst_r <= outst_r + OW'(1'b1);
        2'b01:   outst_r <= outst_r - OW'(1'b1);
        default: outst_r <= outst_r;
      endcase
      if (stray_s) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end
  end

  assign outst_o = outst_r;
  assign err_o   = err_r;

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter num_req_p, default 2: number of requesters (2..8).
REQ-002 Parameter width_words_p, default 4: data words per transfer; data width W = 32*width_words_p.
REQ-003 Parameter max_outst_p, default 4: maximum accepted-but-unanswered memory transactions (power of 2, 2..16).
REQ-004 clk_i  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset_i  input  1  synchronous, active-high reset.
REQ-006 req_valid_i  input  num_req_p  per-requester request valid.
REQ-007 req_ready_o  output  num_req_p  per-requester request accepted this cycle.
REQ-008 req_we_i  input  num_req_p  per-requester write enable.
REQ-009 req_addr_i  input  num_req_p x 32  per-requester byte address.
REQ-010 req_wdata_i  input  num_req_p x W  per-requester write data.
REQ-011 resp_valid_o  output  num_req_p  one-hot response strobe to the owning requester.
REQ-012 resp_data_o  output  W  response data, shared by all requesters.
REQ-013 mem_valid_o / mem_ready_i  output / input  1 / 1  memory request handshake.
REQ-014 mem_we_o, mem_addr_o, mem_wdata_o  output  1, 32, W  fields of the granted request.
REQ-015 mem_valid_i / mem_data_i  input  1 / W  memory response strobe and data (in order, no backpressure).
REQ-016 outst_o  output  $clog2(max_outst_p)+1  current outstanding count.
REQ-017 err_o  output  1  sticky protocol error flag.

Function
REQ-018 Handshake: request of requester g accepted in the cycle where req_valid_i[g] & req_ready_o[g]; memory accepts in the cycle where mem_valid_o & mem_ready_i.
REQ-019 Arbitration: round-robin; search starts at pointer rr_r, first asserted req_valid_i at or after rr_r (wrapping) is the candidate.
REQ-020 Grant lock: once mem_valid_o is asserted for requester g without acceptance, grant stays on g until accepted; no switch while mem_ready_i is low.
REQ-021 On acceptance by g, rr_r <= (g+1) mod num_req_p; otherwise rr_r holds.
REQ-022 mem_valid_o = (any req_valid_i) & (outst_r < max_outst_p); mem_we_o, mem_addr_o, mem_wdata_o are combinational muxes of the granted requester's fields.
REQ-023 req_ready_o[g] = grant[g] & mem_valid_o & mem_ready_i; at most one bit set per cycle.
REQ-024 Credit check uses registered outst_r only; a same-cycle response does not free a credit for that cycle.
REQ-025 ID FIFO, depth max_outst_p: on acceptance push granted index; on mem_valid_i pop head.
REQ-026 Response routing: resp_valid_o[head] = mem_valid_i when FIFO non-empty; resp_data_o = mem_data_i combinationally; zero added latency.
REQ-027 Counter: outst_r +1 on accept only, -1 on response only, unchanged on both or neither; outst_o = outst_r.
REQ-028 mem_valid_i with FIFO empty: resp_valid_o stays all-zero, no pop, outst_r unchanged, err_o set.
REQ-029 Read and write both receive a response strobe; write response data is don't-care.
REQ-030 FIFO pointers wrap modulo max_outst_p; full condition is outst_r == max_outst_p.

Reset
REQ-031 While reset_i is high at a rising edge: outst_r=0, FIFO emptied, rr_r=0, err_o=0, lock cleared.
REQ-032 During reset cycles req_ready_o=0, mem_valid_o=0, resp_valid_o=0.
REQ-033 Reset mid-operation discards all outstanding IDs; later stray mem_valid_i sets err_o.

Verification
REQ-034 Both requesters valid continuously, mem_ready_i=1, responses 3 cycles later -> grants alternate 0,1,0,1; each resp_valid_o matches its issuer in order.
REQ-035 max_outst_p=4, responses withheld -> exactly 4 accepts, outst_o=4, mem_valid_o=0 until first response; mem_valid_i and new request in same cycle -> no accept that cycle, accept next cycle.
REQ-036 Requester 1 valid, mem_ready_i=0 for 5 cycles, requester 0 raises valid at cycle 2 -> mem_addr_o stays requester 1's address until accepted; requester 0 served next.
REQ-037 Write to 0x40 by requester 0, then read 0x40 by requester 1 -> two responses in order, resp_valid_o=01 then 10, read data equals written data.
REQ-038 mem_valid_i pulse with outst_o=0 -> resp_valid_o=0, err_o=1 and held until reset_i.
REQ-039 reset_i asserted with 3 outstanding -> next cycle outst_o=0, all outputs zero, rr_r=0.
